// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (icache/dcache) line memory arbiter
// Requests are latched at grant; memory side is driven only from latched state.
module mem_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         m0_enable_i,
  input  logic         m0_write_i,
  input  logic [31:0]  m0_addr_i,
  input  logic [255:0] m0_data_i,
  output logic [255:0] m0_data_o,
  output logic         m0_ack_o,
  input  logic         m1_enable_i,
  input  logic         m1_write_i,
  input  logic [31:0]  m1_addr_i,
  input  logic [255:0] m1_data_i,
  output logic [255:0] m1_data_o,
  output logic         m1_ack_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t       state_q, state_d;
  logic         grant_q;
  logic         last_grant_q;
  logic         wr_q;
  logic [31:0]  addr_q;
  logic [255:0] data_q;
  logic         sel;
  logic         take;

  // sel: 0 = port 0, 1 = port 1; on a tie round-robin favours the port not granted last
  always_comb begin
    sel = m1_enable_i;
    if (m0_enable_i && m1_enable_i) begin
      sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    take         = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_enable_i || m1_enable_i) begin
          take    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_enable_o = 1'b1;
        mem_write_o  = wr_q;
        if (mem_ack_i) begin
          m0_ack_o = ~grant_q;
          m1_ack_o = grant_q;
          state_d  = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Last grant resets to port 1 so that port 0 wins the first tie
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else if (take) begin
      grant_q      <= sel;
      last_grant_q <= sel;
      wr_q         <= sel ? m1_write_i : m0_write_i;
      addr_q       <= sel ? m1_addr_i : m0_addr_i;
      data_q       <= sel ? m1_data_i : m0_data_i;
    end
  end

  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign m0_data_o  = mem_data_i;
  assign m1_data_o  = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
// Instance 0 is round-robin, instance 1 is fixed priority.
module tb_mem_arbiter;

  typedef struct {
    bit         wr;
    bit [31:0]  addr;
    bit [255:0] data;
    bit         chk_lat;
    bit         drop_mid;
    bit         abandon;
  } req_t;

  typedef struct {
    bit         port;
    bit         wr;
    bit [31:0]  addr;
    bit [255:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  function automatic logic [255:0] rd_pat(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic         m_en [2];
    logic         m_wr [2];
    logic [31:0]  m_addr [2];
    logic [255:0] m_wdata [2];
    logic [255:0] m_rdata [2];
    logic         m_ack [2];
    logic         mem_en, mem_wr, mem_ack_r, mem_ack;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic         stray = 1'b0;
    int           lat = 2;
    int           cnt = 0;
    int           phase [2];
    req_t         q0 [$];
    req_t         q1 [$];
    exp_t         expq [$];

    mem_arbiter #(.FIXED_PRIO(d)) u_dut (
      .clk_i(clk), .rst_i(rst_n),
      .m0_enable_i(m_en[0]), .m0_write_i(m_wr[0]), .m0_addr_i(m_addr[0]),
      .m0_data_i(m_wdata[0]), .m0_data_o(m_rdata[0]), .m0_ack_o(m_ack[0]),
      .m1_enable_i(m_en[1]), .m1_write_i(m_wr[1]), .m1_addr_i(m_addr[1]),
      .m1_data_i(m_wdata[1]), .m1_data_o(m_rdata[1]), .m1_ack_o(m_ack[1]),
      .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr),
      .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    assign mem_rdata = rd_pat(mem_addr);
    assign mem_ack   = mem_ack_r | stray;

    always @(posedge clk) begin
      mem_ack_r <= 1'b0;
      if (mem_en && !mem_ack_r) begin
        if (cnt >= lat) begin
          mem_ack_r <= 1'b1;
          cnt       <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end else begin
        cnt <= 0;
      end
    end

    initial begin : drv
      req_t cur [2];
      int   tmo [2];
      bit   first [2];
      bit   dropped [2];
      for (int p = 0; p < 2; p++) begin
        m_en[p] = 1'b0; m_wr[p] = 1'b0; m_addr[p] = '0; m_wdata[p] = '0; phase[p] = 0;
      end
      forever begin
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
          if (phase[p] == 0) begin
            if ((p == 0 && q0.size() > 0) || (p == 1 && q1.size() > 0)) begin
              if (p == 0) cur[p] = q0.pop_front();
              else        cur[p] = q1.pop_front();
              m_en[p] = 1'b1; m_wr[p] = cur[p].wr; m_addr[p] = cur[p].addr; m_wdata[p] = cur[p].data;
              phase[p] = 1; tmo[p] = 0; first[p] = 1'b1; dropped[p] = 1'b0;
            end
          end else begin
            if (first[p] && cur[p].chk_lat) begin
              chk($sformatf("d%0d_req_latency_en", d), mem_en, 1'b1);
              chk($sformatf("d%0d_req_latency_addr", d), mem_addr, cur[p].addr);
            end
            first[p] = 1'b0;
            tmo[p]++;
            if (m_ack[p]) begin
              m_en[p] = 1'b0; phase[p] = 0;
            end else if ((cur[p].drop_mid || cur[p].abandon) && mem_en && !dropped[p]) begin
              m_en[p] = 1'b0; dropped[p] = 1'b1;
              if (cur[p].drop_mid) m_addr[p] = cur[p].addr ^ 32'h0000_FFE0;
              if (cur[p].abandon) phase[p] = 0;
            end else if (tmo[p] > 400) begin
              chk($sformatf("d%0d_p%0d_ack_timeout", d, p), 1'b1, 1'b0);
              m_en[p] = 1'b0; phase[p] = 0;
            end
          end
        end
      end
    end

    initial begin : mon
      exp_t e;
      int   gap;
      gap = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          gap = 0;
        end else begin
          if (mem_en && expq.size() > 0) begin
            chk($sformatf("d%0d_addr_stable", d), mem_addr, expq[0].addr);
            chk($sformatf("d%0d_write_stable", d), mem_wr, expq[0].wr);
          end
          if (m_ack[0] || m_ack[1]) begin
            chk($sformatf("d%0d_ack_exclusive", d), m_ack[0] & m_ack[1], 1'b0);
            if (expq.size() == 0) begin
              chk($sformatf("d%0d_unexpected_ack", d), 1'b1, 1'b0);
            end else begin
              e = expq.pop_front();
              chk($sformatf("d%0d_ack_port", d), m_ack[1], e.port);
              chk($sformatf("d%0d_ack_write", d), mem_wr, e.wr);
              chk($sformatf("d%0d_ack_addr", d), mem_addr, e.addr);
              if (e.wr) chk($sformatf("d%0d_ack_wdata", d), mem_wdata, e.data);
              else      chk($sformatf("d%0d_rdata", d), m_rdata[e.port], rd_pat(e.addr));
              chk($sformatf("d%0d_rdata_other", d), m_rdata[~e.port], rd_pat(mem_addr));
            end
            gap = 2;
          end else if (gap > 0) begin
            chk($sformatf("d%0d_gap_idle", d), mem_en, 1'b0);
            gap--;
          end
        end
      end
    end
  end

  task automatic issue(input int d, input int p, input bit wr, input bit [31:0] addr,
                       input bit [255:0] data, input bit lat_chk, input bit drop, input bit aband);
    req_t r;
    r.wr = wr; r.addr = addr; r.data = data;
    r.chk_lat = lat_chk; r.drop_mid = drop; r.abandon = aband;
    if (d == 0) begin
      if (p == 0) g_dut[0].q0.push_back(r); else g_dut[0].q1.push_back(r);
    end else begin
      if (p == 0) g_dut[1].q0.push_back(r); else g_dut[1].q1.push_back(r);
    end
  endtask

  task automatic expect_txn(input int d, input bit port, input bit wr, input bit [31:0] addr,
                            input bit [255:0] data);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.data = data;
    if (d == 0) g_dut[0].expq.push_back(e); else g_dut[1].expq.push_back(e);
  endtask

  task automatic drain(input int d);
    int t;
    bit busy;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (d == 0)
        busy = g_dut[0].q0.size() > 0 || g_dut[0].q1.size() > 0 || g_dut[0].expq.size() > 0 ||
               g_dut[0].phase[0] != 0 || g_dut[0].phase[1] != 0 || g_dut[0].mem_en;
      else
        busy = g_dut[1].q0.size() > 0 || g_dut[1].q1.size() > 0 || g_dut[1].expq.size() > 0 ||
               g_dut[1].phase[0] != 0 || g_dut[1].phase[1] != 0 || g_dut[1].mem_en;
    end while (busy && t < 3000);
    chk($sformatf("d%0d_drain_timeout", d), busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, g_dut[0].mem_en, 1'b0);
    chk({tag, "_mem_wr"}, g_dut[0].mem_wr, 1'b0);
    chk({tag, "_mem_addr"}, g_dut[0].mem_addr, '0);
    chk({tag, "_mem_data"}, g_dut[0].mem_wdata, '0);
    chk({tag, "_ack0"}, g_dut[0].m_ack[0], 1'b0);
    chk({tag, "_ack1"}, g_dut[0].m_ack[1], 1'b0);
  endtask

  initial begin : main
    int t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single m1 read with slow memory
    g_dut[0].lat = 10;
    issue(0, 1, 1'b0, 32'h0000_0400, '0, 1'b1, 1'b0, 1'b0);
    expect_txn(0, 1'b1, 1'b0, 32'h0000_0400, '0);
    drain(0);
    g_dut[0].lat = 2;

    // tie after last grant = port 1 -> port 0 first
    issue(0, 0, 1'b0, 32'h0000_1000, '0, 1'b1, 1'b0, 1'b0);
    issue(0, 1, 1'b0, 32'h0000_2000, '0, 1'b0, 1'b0, 1'b0);
    expect_txn(0, 1'b0, 1'b0, 32'h0000_1000, '0);
    expect_txn(0, 1'b1, 1'b0, 32'h0000_2000, '0);
    drain(0);
    issue(0, 0, 1'b0, 32'h0000_3000, '0, 1'b0, 1'b0, 1'b0);
    issue(0, 1, 1'b0, 32'h0000_4000, '0, 1'b0, 1'b0, 1'b0);
    expect_txn(0, 1'b0, 1'b0, 32'h0000_3000, '0);
    expect_txn(0, 1'b1, 1'b0, 32'h0000_4000, '0);
    drain(0);

    // last grant = port 0 -> port 1 wins the next tie
    issue(0, 0, 1'b1, 32'h0000_5000, {8{32'h1234_5678}}, 1'b0, 1'b0, 1'b0);
    expect_txn(0, 1'b0, 1'b1, 32'h0000_5000, {8{32'h1234_5678}});
    drain(0);
    issue(0, 0, 1'b0, 32'h0000_6000, '0, 1'b0, 1'b0, 1'b0);
    issue(0, 1, 1'b1, 32'h0000_7000, {8{32'hCAFE_F00D}}, 1'b0, 1'b0, 1'b0);
    expect_txn(0, 1'b1, 1'b1, 32'h0000_7000, {8{32'hCAFE_F00D}});
    expect_txn(0, 1'b0, 1'b0, 32'h0000_6000, '0);
    drain(0);

    // write-back then immediate read on m1
    issue(0, 1, 1'b1, 32'h0000_0800, {32{8'hA5}}, 1'b1, 1'b0, 1'b0);
    issue(0, 1, 1'b0, 32'h0000_0400, '0, 1'b0, 1'b0, 1'b0);
    expect_txn(0, 1'b1, 1'b1, 32'h0000_0800, {32{8'hA5}});
    expect_txn(0, 1'b1, 1'b0, 32'h0000_0400, '0);
    drain(0);

    // m0 drops enable and changes address mid-transaction
    g_dut[0].lat = 5;
    issue(0, 0, 1'b0, 32'h0000_1200, '0, 1'b1, 1'b1, 1'b0);
    expect_txn(0, 1'b0, 1'b0, 32'h0000_1200, '0);
    drain(0);

    // reset during BUSY, then a stray memory ack
    g_dut[0].lat = 50;
    issue(0, 0, 1'b1, 32'h0000_0600, {8{32'hDEAD_BEEF}}, 1'b0, 1'b0, 1'b1);
    t = 0;
    do begin @(negedge clk); t++; end while (!g_dut[0].mem_en && t < 100);
    chk("rst_busy_reached", g_dut[0].mem_en, 1'b1);
    chk("rst_busy_addr", g_dut[0].mem_addr, 32'h0000_0600);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midbusy_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    g_dut[0].stray = 1'b1;
    #1;
    chk("stray_ack0", g_dut[0].m_ack[0], 1'b0);
    chk("stray_ack1", g_dut[0].m_ack[1], 1'b0);
    @(negedge clk);
    g_dut[0].stray = 1'b0;
    chk("stray_mem_en", g_dut[0].mem_en, 1'b0);
    chk_reset_outputs("post_stray");
    g_dut[0].lat = 2;

    // first tie after the mid-busy reset goes to port 0 again
    issue(0, 0, 1'b0, 32'h0000_8000, '0, 1'b0, 1'b0, 1'b0);
    issue(0, 1, 1'b0, 32'h0000_9000, '0, 1'b0, 1'b0, 1'b0);
    expect_txn(0, 1'b0, 1'b0, 32'h0000_8000, '0);
    expect_txn(0, 1'b1, 1'b0, 32'h0000_9000, '0);
    drain(0);

    // fixed priority: m0 keeps requesting, m1 waits until m0 is done
    g_dut[1].lat = 1;
    issue(1, 0, 1'b0, 32'h0000_A000, '0, 1'b1, 1'b0, 1'b0);
    issue(1, 0, 1'b1, 32'h0000_A020, {8{32'h0BAD_F00D}}, 1'b0, 1'b0, 1'b0);
    issue(1, 0, 1'b0, 32'h0000_A040, '0, 1'b0, 1'b0, 1'b0);
    issue(1, 1, 1'b0, 32'h0000_B000, '0, 1'b0, 1'b0, 1'b0);
    issue(1, 1, 1'b1, 32'h0000_B020, {8{32'h7777_1111}}, 1'b0, 1'b0, 1'b0);
    expect_txn(1, 1'b0, 1'b0, 32'h0000_A000, '0);
    expect_txn(1, 1'b0, 1'b1, 32'h0000_A020, {8{32'h0BAD_F00D}});
    expect_txn(1, 1'b0, 1'b0, 32'h0000_A040, '0);
    expect_txn(1, 1'b1, 1'b0, 32'h0000_B000, '0);
    expect_txn(1, 1'b1, 1'b1, 32'h0000_B020, {8{32'h7777_1111}});
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin between ports; 1 = port 0 always wins ties.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 m0_enable_i  input  1  port 0 (icache) request.
REQ-005 m0_write_i  input  1  port 0: 1 = line write, 0 = line read.
REQ-006 m0_addr_i  input  32  port 0 line address, bits [4:0] zero.
REQ-007 m0_data_i  input  256  port 0 write line.
REQ-008 m0_data_o  output  256  port 0 read line.
REQ-009 m0_ack_o  output  1  port 0 completion strobe.
REQ-010 m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o: port 1 (dcache), same directions, widths and meanings as port 0.
REQ-011 mem_enable_o  output  1  data memory request.
REQ-012 mem_write_o  output  1  data memory write select.
REQ-013 mem_addr_o  output  32  data memory line address.
REQ-014 mem_data_o  output  256  data memory write line.
REQ-015 mem_data_i  input  256  data memory read line.
REQ-016 mem_ack_i  input  1  data memory completion, one cycle high.

Function
REQ-017 FSM states: IDLE, BUSY, GAP.
REQ-018 IDLE: at a clock edge with at least one mX_enable_i high, select a winner, latch its write/addr/data into internal registers, record grant, and go to BUSY.
REQ-019 IDLE with no request: stay in IDLE.
REQ-020 Single requester: that port wins.
REQ-021 Both requesting, FIXED_PRIO=0: winner is the port not granted last; FIXED_PRIO=1: port 0 wins.
REQ-022 Last-grant register updates only when a grant is issued.
REQ-023 BUSY: mem_enable_o=1; mem_write_o, mem_addr_o and mem_data_o come from the latched registers and stay stable for the whole of BUSY.
REQ-024 BUSY: changes on mX_*_i, including a requester dropping its enable, have no effect; the transaction runs until mem_ack_i.
REQ-025 BUSY with mem_ack_i=1: assert ack_o of the granted port only, in the same cycle (combinational), and go to GAP at the next edge.
REQ-026 GAP lasts exactly one cycle: mem_enable_o=0, requests are not sampled, and the FSM then goes to IDLE. This lets the requester update its enable/write after ack.
REQ-027 Request-to-mem_enable_o latency: 1 cycle. Minimum spacing between back-to-back transactions: ack cycle + GAP + IDLE sample.
REQ-028 m0_data_o and m1_data_o both equal mem_data_i at all times.
REQ-029 Outside BUSY: mem_enable_o=0 and mem_write_o=0.
REQ-030 mem_ack_i in IDLE or GAP is ignored: no ack_o and no state change.
REQ-031 m0_ack_o and m1_ack_o are never high in the same cycle.
REQ-032 Memory-side outputs are driven only from the latched registers and FSM state; there is no combinational path from mX_*_i to mem_*_o.

Reset
REQ-033 On rst_i=0, immediately:
- state=IDLE
- mem_enable_o=0, mem_write_o=0
- mem_addr_o=0, mem_data_o=0 (latched registers cleared)
- both ack_o=0
- last-grant=port 1, so port 0 wins the first tie.
REQ-034 Reset asserted during BUSY abandons the transaction; a mem_ack_i arriving after reset release is ignored per REQ-030.

Verification
REQ-035 Only m1 requests a read at 0x0000_0400; memory acks after 10 cycles -> mem_enable_o=1 the cycle after the request, mem_addr_o=0x400 and mem_write_o=0 throughout, m1_ack_o pulses once, m0_ack_o stays 0.
REQ-036 Both ports request in the same cycle after reset, FIXED_PRIO=0 -> port 0 served first, then port 1; a second simultaneous pair -> port 0 again, since the last grant was port 1.
REQ-037 m1 issues a write-back (write=1, addr 0x800, data 256'hA5..A5) and after its ack immediately a read at 0x400 -> two separate transactions with correct write/addr/data and a one-cycle GAP between them.
REQ-038 m0 deasserts its enable and changes m0_addr_i mid-BUSY -> mem_addr_o unchanged and the transaction completes with an ack to port 0.
REQ-039 rst_i pulsed low during BUSY, then a stray mem_ack_i -> outputs at reset values and no ack_o asserted.
REQ-040 FIXED_PRIO=1 with m0 and m1 requesting continuously -> m0 wins every arbitration in which both are requesting.
